// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_ctrl
// Description : Block-granular backing store behind the L2 cache. Each
//               accepted read or write waits a programmable number of cycles,
//               then completes with a one-cycle mem_ready pulse and an
//               in-range flag on mem_hit.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 16,
    parameter int MEM_BLOCKS    = 256,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    output logic                             mem_ready,
    output logic                             mem_hit,
    output logic                             mem_busy
);

    localparam int c_BW     = BLOCK_SIZE * DATA_WIDTH;
    localparam int c_OFF    = $clog2(c_BW / 8);
    localparam int c_IDX    = $clog2(MEM_BLOCKS);
    localparam int c_MAXLAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_CW     = $clog2(c_MAXLAT) + 1;

    localparam logic [c_CW-1:0] c_RD_LOAD = c_CW'(READ_LATENCY - 1);
    localparam logic [c_CW-1:0] c_WR_LOAD = c_CW'(WRITE_LATENCY - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_CW-1:0]  r_cnt;
    logic [c_IDX-1:0] r_idx;
    logic [c_BW-1:0]  r_wdata;
    logic             r_is_write;
    logic             r_in_range;
    logic [c_BW-1:0]  r_data_in;
    logic             w_req;
    logic             w_in_range;

    // Storage powers up cleared; reset deliberately leaves it untouched.
    logic [c_BW-1:0]  r_mem [MEM_BLOCKS] = '{default: '0};

    // Byte-offset bits inside a block never select anything.
    logic             w_unused_offset;
    assign w_unused_offset = ^mem_addr[c_OFF-1:0];

    assign w_req      = mem_read | mem_write;
    assign w_in_range = ~|mem_addr[ADDR_WIDTH-1:c_OFF+c_IDX];

    // State register, cleared asynchronously so an in-flight op is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: RELEASE waits for both request lines to drop so a
    // held request is answered only once.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_req)         w_next_state = c_WAIT;
            c_WAIT:    if (r_cnt == '0)   w_next_state = c_RESP;
            c_RESP:                       w_next_state = c_RELEASE;
            c_RELEASE: if (!w_req)        w_next_state = c_IDLE;
            default:                      w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; mem_hit is masked outside RESP.
    always_comb begin
        mem_ready = 1'b0;
        mem_hit   = 1'b0;
        mem_busy  = 1'b0;
        case (r_state)
            c_WAIT:    mem_busy = 1'b1;
            c_RESP: begin
                mem_ready = 1'b1;
                mem_hit   = r_in_range;
                mem_busy  = 1'b1;
            end
            c_RELEASE: mem_busy = 1'b1;
            default: begin
                mem_ready = 1'b0;
                mem_hit   = 1'b0;
                mem_busy  = 1'b0;
            end
        endcase
    end

    // Request capture, latency countdown and read-data load ahead of RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_in_range <= 1'b0;
            r_data_in  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        // Write wins when both lines are high.
                        r_is_write <= mem_write;
                        r_cnt      <= mem_write ? c_WR_LOAD : c_RD_LOAD;
                        r_idx      <= mem_addr[c_OFF+c_IDX-1:c_OFF];
                        r_in_range <= w_in_range;
                        r_wdata    <= mem_data_out;
                    end
                end
                c_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_is_write) begin
                        r_data_in <= r_in_range ? r_mem[r_idx] : '0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Array update on the RESP edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (r_state == c_RESP && r_is_write && r_in_range) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign mem_data_in = r_data_in;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_ctrl
// Description : Directed self-checking bench for main_memory_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_ctrl;

    localparam int c_DW = 32;
    localparam int c_BS = 16;
    localparam int c_BW = c_DW * c_BS;

    logic            clk;
    logic            rst;
    logic [31:0]     mem_addr;
    logic [c_BW-1:0] mem_data_out;
    logic            mem_read;
    logic            mem_write;
    logic [c_BW-1:0] mem_data_in;
    logic            mem_ready;
    logic            mem_hit;
    logic            mem_busy;

    int checks = 0;
    int errors = 0;

    main_memory_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready),
        .mem_hit      (mem_hit),
        .mem_busy     (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_BW-1:0] act, input logic [c_BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [c_BW-1:0] fill(input logic [31:0] base, input logic inc);
        logic [c_BW-1:0] b;
        for (int i = 0; i < c_BS; i++) b[i*c_DW +: c_DW] = inc ? base + 32'(i) : base;
        return b;
    endfunction

    // Called at a negedge right after a request is driven; n counts the
    // negedges without mem_ready before the one where it is seen.
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!mem_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic release_req();
        int k;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mem_busy && k < 10);
    endtask

    // Full transaction; edges = clock edges from the sampling edge to the
    // edge that captures mem_ready, or -1 on timeout.
    task automatic do_req(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [c_BW-1:0] data, output int edges, output logic hit);
        int n;
        mem_addr     = addr;
        mem_data_out = data;
        mem_read     = rd;
        mem_write    = wr;
        wait_ready(n);
        hit   = mem_hit;
        edges = mem_ready ? n + 1 : -1;
        release_req();
    endtask

    initial begin
        int              lat;
        int              pulses;
        logic            hit;
        logic            busy_ok;
        logic [c_BW-1:0] a5;

        a5           = fill(32'hA5A5_0000, 1'b1);
        rst          = 1'b1;
        mem_addr     = '0;
        mem_data_out = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", c_BW'(mem_ready), '0);
        check("rst_hit", c_BW'(mem_hit), '0);
        check("rst_busy", c_BW'(mem_busy), '0);
        check("rst_data", mem_data_in, '0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back
        do_req(32'h100, 1'b0, 1'b1, a5, lat, hit);
        check("wr_lat", c_BW'(lat), c_BW'(3));
        check("wr_hit", c_BW'(hit), c_BW'(1));
        do_req(32'h100, 1'b1, 1'b0, '0, lat, hit);
        check("rd_lat", c_BW'(lat), c_BW'(5));
        check("rd_hit", c_BW'(hit), c_BW'(1));
        check("rd_w0", c_BW'(mem_data_in[0 +: 32]), c_BW'(32'hA5A5_0000));
        check("rd_w15", c_BW'(mem_data_in[15*32 +: 32]), c_BW'(32'hA5A5_000F));

        // Offset bits ignored
        do_req(32'h13C, 1'b1, 1'b0, '0, lat, hit);
        check("alias_hit", c_BW'(hit), c_BW'(1));
        check("alias_w3", c_BW'(mem_data_in[3*32 +: 32]), c_BW'(32'hA5A5_0003));

        // Out of range read and write
        do_req(32'h0001_0000, 1'b1, 1'b0, '0, lat, hit);
        check("oor_rd_lat", c_BW'(lat), c_BW'(5));
        check("oor_rd_hit", c_BW'(hit), '0);
        check("oor_rd_data", mem_data_in, '0);
        do_req(32'h0001_0000, 1'b0, 1'b1, fill(32'hDEAD_BEEF, 1'b0), lat, hit);
        check("oor_wr_hit", c_BW'(hit), '0);
        do_req(32'h0, 1'b1, 1'b0, '0, lat, hit);
        check("blk0_clean", mem_data_in, '0);

        // Simultaneous read+write behaves as a write
        do_req(32'h100, 1'b1, 1'b0, '0, lat, hit);
        do_req(32'h40, 1'b1, 1'b1, fill(32'h1111_1111, 1'b0), lat, hit);
        check("both_lat", c_BW'(lat), c_BW'(3));
        check("both_keep", mem_data_in, a5);
        do_req(32'h40, 1'b1, 1'b0, '0, lat, hit);
        check("both_rdback", mem_data_in, fill(32'h1111_1111, 1'b0));

        // Held read answered once
        mem_addr = 32'h100;
        mem_read = 1'b1;
        pulses   = 0;
        busy_ok  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
            if (!mem_busy) busy_ok = 1'b0;
        end
        check("held_pulses", c_BW'(pulses), c_BW'(1));
        check("held_busy", c_BW'(busy_ok), c_BW'(1));
        mem_read = 1'b0;
        @(negedge clk);
        check("held_drop_busy", c_BW'(mem_busy), '0);
        mem_read = 1'b1;
        @(negedge clk);
        check("held_reaccept", c_BW'(mem_busy), c_BW'(1));
        wait_ready(lat);
        check("held_reaccept_rdy", c_BW'(mem_ready), c_BW'(1));
        release_req();

        // Reset during a write's wait
        mem_addr     = 32'h80;
        mem_data_out = fill(32'h5555_0000, 1'b1);
        mem_write    = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", c_BW'(mem_ready), '0);
        check("abort_busy", c_BW'(mem_busy), '0);
        check("abort_hit", c_BW'(mem_hit), '0);
        check("abort_data", mem_data_in, '0);
        mem_write = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("abort_no_pulse", c_BW'(pulses), '0);
        do_req(32'h80, 1'b1, 1'b0, '0, lat, hit);
        check("abort_rd_lat", c_BW'(lat), c_BW'(5));
        check("abort_rd_data", mem_data_in, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
